spike_rate_decoder: RTL



---
 rtl/lif_pkg.sv | 22 ++
 rtl/spike_isi_timer.sv | 53 +++++
 rtl/spike_rate_decoder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared types, default widths and the saturating counter helper
// used by the spike rate / ISI decoder.
package lif_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WINDOW_W = 8;
  localparam int COUNT_W  = 8;
  localparam int ISI_W    = 8;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max,
    input logic        inc
  );
    return (inc && (v < max)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/spike_isi_timer.sv
// Inter-spike interval timer: measures cycles between the two
// most recent spikes while the decoder is running.
module spike_isi_timer
  import lif_pkg::*;
#(
  parameter int ISI_W = lif_pkg::ISI_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             spike,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid
);

  localparam logic [31:0] ISI_MAX =
    32'((64'd1 << ISI_W) - 64'd1);

  logic [ISI_W-1:0] r_timer;
  logic [ISI_W-1:0] r_isi;
  logic             r_isi_valid;
  logic             r_have_prev;
  logic [ISI_W-1:0] w_timer_inc;

  assign w_timer_inc =
    ISI_W'(sat_inc(32'(r_timer), ISI_MAX, 1'b1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_isi       <= '0;
      r_isi_valid <= 1'b0;
      r_have_prev <= 1'b0;
    end else if (!run) begin
      // Arming and idle both forget the previous spike; isi holds.
      r_timer     <= '0;
      r_isi_valid <= 1'b0;
      r_have_prev <= 1'b0;
    end else if (spike) begin
      r_isi       <= r_have_prev ? r_timer : r_isi;
      r_isi_valid <= r_have_prev;
      r_timer     <= ISI_W'(1);
      r_have_prev <= 1'b1;
    end else begin
      r_isi_valid <= 1'b0;
      r_timer     <= w_timer_inc;
    end
  end

  assign isi       = r_isi;
  assign isi_valid = r_isi_valid;

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a LIF spike train into a windowed spike rate and the
// inter-spike interval; all outputs are registered.
module spike_rate_decoder
  import lif_pkg::*;
#(
  parameter int WINDOW_W = lif_pkg::WINDOW_W,
  parameter int COUNT_W  = lif_pkg::COUNT_W,
  parameter int ISI_W    = lif_pkg::ISI_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                spike,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [COUNT_W-1:0]  rate,
  output logic                rate_valid,
  output logic                overflow,
  output logic [ISI_W-1:0]    isi,
  output logic                isi_valid
);

  localparam logic [31:0] CNT_MAX =
    32'((64'd1 << COUNT_W) - 64'd1);

  state_t              r_state;
  state_t              w_next;
  logic                w_arm;
  logic                w_run;
  logic                w_last;
  logic                w_hit_max;
  logic [WINDOW_W:0]   w_len_map;
  logic [WINDOW_W:0]   r_len;
  logic [WINDOW_W-1:0] r_wcnt;
  logic [COUNT_W-1:0]  r_scnt;
  logic [COUNT_W-1:0]  w_scnt_inc;
  logic                r_sat;
  logic [COUNT_W-1:0]  r_rate;
  logic                r_rate_valid;
  logic                r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (en)  w_next = RUN;
      RUN:  if (!en) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_arm = 1'b0;
    w_run = 1'b0;
    unique case (r_state)
      IDLE: w_arm = en;
      RUN:  w_run = en;
      default: ;
    endcase
  end

  // A zero window length selects the full 2^WINDOW_W cycles.
  assign w_len_map = (window_len == '0)
    ? {1'b1, {WINDOW_W{1'b0}}}
    : {1'b0, window_len};

  assign w_last =
    ({1'b0, r_wcnt} == (r_len - (WINDOW_W+1)'(1)));

  assign w_scnt_inc =
    COUNT_W'(sat_inc(32'(r_scnt), CNT_MAX, spike));

  assign w_hit_max = spike && (r_scnt == {COUNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len        <= '0;
      r_wcnt       <= '0;
      r_scnt       <= '0;
      r_sat        <= 1'b0;
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_rate_valid <= 1'b0;
      if (w_arm) begin
        r_len  <= w_len_map;
        r_wcnt <= '0;
        r_scnt <= '0;
        r_sat  <= 1'b0;
      end else if (w_run && w_last) begin
        r_rate       <= w_scnt_inc;
        r_ovf        <= r_sat | w_hit_max;
        r_rate_valid <= 1'b1;
        r_len        <= w_len_map;
        r_wcnt       <= '0;
        r_scnt       <= '0;
        r_sat        <= 1'b0;
      end else if (w_run) begin
        r_scnt <= w_scnt_inc;
        r_sat  <= r_sat | w_hit_max;
        r_wcnt <= r_wcnt + WINDOW_W'(1);
      end
    end
  end

  spike_isi_timer #(
    .ISI_W(ISI_W)
  ) u_isi (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (w_run),
    .spike    (spike),
    .isi      (isi),
    .isi_valid(isi_valid)
  );

  assign rate       = r_rate;
  assign rate_valid = r_rate_valid;
  assign overflow   = r_ovf;

endmodule
